// File: rtl/pwm_led_pkg.sv
// pwm_led_pkg: register map and mode encoding shared by the LED PIO block.
package pwm_led_pkg;

   localparam logic [3:0] ADDR_DATA      = 4'd0;
   localparam logic [3:0] ADDR_SET       = 4'd1;
   localparam logic [3:0] ADDR_CLR       = 4'd2;
   localparam logic [3:0] ADDR_MODE      = 4'd3;
   localparam logic [3:0] ADDR_PRESC     = 4'd4;
   localparam logic [3:0] ADDR_DUTY_BASE = 4'd8;

   typedef enum logic {
      ModeStatic = 1'b0,
      ModePwm    = 1'b1
   } mode_e;

   localparam logic MODE_STATIC = 1'b0;
   localparam logic MODE_PWM    = 1'b1;

endpackage

// File: rtl/pwm_led_pio_if.sv
// pwm_led_pio_if: Avalon-MM slave signals of the LED PIO (read latency 0).
interface pwm_led_pio_if;

   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/pwm_led_timebase.sv
// pwm_led_timebase: shared prescaler and PWM phase counter.
// A presc_wr restarts the prescaler from the new value and clears phase on the same edge.
module pwm_led_timebase
   import pwm_led_pkg::*;
#(
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned PRESC_W  = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PRESC_W-1:0]  presc,
   input  logic                presc_wr,
   output logic [PWM_BITS-1:0] phase,
   output logic                wrap
);

   logic [PRESC_W-1:0]  cnt_q, cnt_d;
   logic [PWM_BITS-1:0] phase_q, phase_d;
   logic                tick;

   assign tick  = (cnt_q == '0);
   assign phase = phase_q;
   // Phase is about to return to 0 on this edge.
   assign wrap  = tick && !presc_wr && (phase_q == '1);

   // Count down, reload on tick; a PRESC write takes precedence over a tick.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (presc_wr) begin
         cnt_d   = presc;
         phase_d = '0;
      end else if (tick) begin
         cnt_d   = presc;
         phase_d = phase_q + PWM_BITS'(1);
      end else begin
         cnt_d   = cnt_q - PRESC_W'(1);
      end
   end

   // Timebase state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/pwm_led_pio.sv
// pwm_led_pio: Avalon-MM LED PIO with DATA/SET/CLR and optional per-channel PWM dimming.
// PWM (MODE, PRESC, DUTY, timebase) exists only when LED_PWM_EN is defined;
// otherwise out_port is simply registered DATA.
module pwm_led_pio
   import pwm_led_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned PRESC_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   pwm_led_pio_if.slave      bus,
   output logic [NUM_CH-1:0] out_port
);

   logic              wr;
   logic [NUM_CH-1:0] data_q, data_d;
   logic [NUM_CH-1:0] out_q, out_d;
   logic [31:0]       rdata;
   logic              unused_cfg;

   assign wr       = bus.chipselect && !bus.write_n;
   assign out_port = out_q;
   assign unused_cfg = ^{bus.writedata, PWM_BITS[0], PRESC_W[0]};

   // DATA next state: direct write, atomic set, atomic clear.
   always_comb begin
      data_d = data_q;
      if (wr) begin
         case (bus.address)
            ADDR_DATA: data_d = bus.writedata[NUM_CH-1:0];
            ADDR_SET:  data_d = data_q | bus.writedata[NUM_CH-1:0];
            ADDR_CLR:  data_d = data_q & ~bus.writedata[NUM_CH-1:0];
            default:   ;
         endcase
      end
   end

`ifdef LED_PWM_EN
   logic [NUM_CH-1:0]   mode_q, mode_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic                presc_wr;
   logic [PWM_BITS-1:0] duty_q [NUM_CH];
   logic [PWM_BITS-1:0] duty_d [NUM_CH];
   logic [PWM_BITS-1:0] act_q  [NUM_CH];
   logic [PWM_BITS-1:0] act_d  [NUM_CH];
   logic [PWM_BITS-1:0] phase;
   logic                wrap;

   // Write side of MODE, PRESC and the DUTY registers.
   always_comb begin
      mode_d   = mode_q;
      presc_d  = presc_q;
      duty_d   = duty_q;
      presc_wr = 1'b0;
      if (wr) begin
         if (bus.address == ADDR_MODE) mode_d = bus.writedata[NUM_CH-1:0];
         if (bus.address == ADDR_PRESC) begin
            presc_d  = bus.writedata[PRESC_W-1:0];
            presc_wr = 1'b1;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.address == ADDR_DUTY_BASE + 4'(i)) duty_d[i] = bus.writedata[PWM_BITS-1:0];
         end
      end
   end

   // Shadow load takes the write-side value so a DUTY write on the wrap edge is caught.
   always_comb begin
      act_d = act_q;
      if (wrap || presc_wr) act_d = duty_d;
   end

   // presc_d equals presc_q except on a PRESC write, where it carries the new value.
   pwm_led_timebase #(
      .PWM_BITS (PWM_BITS),
      .PRESC_W  (PRESC_W)
   ) u_timebase (
      .clk      (clk),
      .reset_n  (reset_n),
      .presc    (presc_d),
      .presc_wr (presc_wr),
      .phase    (phase),
      .wrap     (wrap)
   );

   // Output compare: static channels follow DATA, PWM channels are gated by phase < duty.
   always_comb begin
      out_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mode_e'(mode_q[i]) == ModePwm) out_d[i] = data_q[i] && (phase < act_q[i]);
         else                               out_d[i] = data_q[i];
      end
   end

   // PWM configuration and shadow registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q  <= '0;
         presc_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            duty_q[i] <= '0;
            act_q[i]  <= '0;
         end
      end else begin
         mode_q  <= mode_d;
         presc_q <= presc_d;
         duty_q  <= duty_d;
         act_q   <= act_d;
      end
   end
`else
   // Without PWM the LEDs are registered DATA.
   always_comb begin
      out_d = data_q;
   end
`endif

   // Combinational read mux; unmapped and write-only addresses return 0.
   always_comb begin
      rdata = '0;
      case (bus.address)
         ADDR_DATA:  rdata[NUM_CH-1:0] = data_q;
`ifdef LED_PWM_EN
         ADDR_MODE:  rdata[NUM_CH-1:0] = mode_q;
         ADDR_PRESC: rdata[PRESC_W-1:0] = presc_q;
`endif
         default:    ;
      endcase
`ifdef LED_PWM_EN
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.address == ADDR_DUTY_BASE + 4'(i)) rdata[PWM_BITS-1:0] = duty_q[i];
      end
`endif
   end

   assign bus.readdata = rdata;

   // DATA and LED output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= '0;
         out_q  <= '0;
      end else begin
         data_q <= data_d;
         out_q  <= out_d;
      end
   end

endmodule

// File: doc/pwm_led_pio.md
# pwm_led_pio

Parametrised Avalon-MM slave that drives `NUM_CH` LED outputs and replaces the fixed 4-bit write-only LED PIO. Per channel it provides static on/off and PWM dimming. Channels are controlled through atomic set/clear registers, and PWM runs from a shared prescaled timebase. It sits on the Qsys peripheral bus next to the other PIOs, and `out_port` goes straight to board LED pins.

## Interface
- `NUM_CH`, 4, number of LED channels, 1..8
- `PWM_BITS`, 8, PWM phase/duty width, 2..16
- `PRESC_W`, 16, prescaler reload width, 1..32
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `address`  in  4  word address
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  read data, combinational (read latency 0), unused bits 0
- `out_port`  out  NUM_CH  registered LED drive, 1 = on

## Operation
- A write is `chipselect && !write_n`. Writes to unmapped addresses are ignored, and reads from them return 0.
- Address map:
  - 0 DATA: rw, `enable[NUM_CH-1:0]`
  - 1 SET: wo, DATA |= wd; reads 0
  - 2 CLR: wo, DATA &= ~wd; reads 0
  - 3 MODE: rw, per channel; 0 = static, 1 = PWM
  - 4 PRESC: rw, `PRESC_W` bits
  - 8+i DUTY[i]: rw, `PWM_BITS` bits, for i < NUM_CH
- Timebase:
  - The prescaler counts down from PRESC. At 0 it emits `tick` and reloads.
  - On `tick`, phase (`PWM_BITS`) increments and wraps to 0.
  - A PRESC write loads the counter with the new value and clears phase on the same edge.
- Duty shadowing:
  - DUTY writes update the readable register immediately.
  - The active duty copies all DUTY registers when phase wraps to 0, and also on a PRESC write.
  - Result: no runt or glitch pulses mid-period.
- Output: `out_port[i]` next = `DATA[i] & (MODE[i] ? (phase < active_duty[i]) : 1)`.
- Duty boundaries:
  - duty 0 gives constant off.
  - duty 2^PWM_BITS−1 gives off for exactly 1 phase step per period.
  - There is no 100% PWM; software uses static mode for full on.
- Reset: DATA, MODE, PRESC, DUTY, active duty, prescaler, phase and `out_port` are all 0. Reset is honoured mid-period with no pending state.

## Timing
- A register write at edge k is visible on `readdata` after edge k. `out_port` reflects it after edge k+1, so latency is 1 cycle.
- Tick period is PRESC+1 clocks. With PRESC=0, tick fires every cycle.
- PWM period is (PRESC+1)·2^PWM_BITS clocks. High time is duty·(PRESC+1) clocks.
- The phase wrap and the active-duty load happen on the same edge. The new duty governs the first step of the new period.
- A DUTY write on the wrap edge is captured by that load, because the load takes the write-side value.
- A MODE or DATA change takes effect at k+1 regardless of phase.

## Configuration
- `LED_PWM_EN` defined: full behaviour as above.
- `LED_PWM_EN` undefined:
  - No prescaler, phase, DUTY or active-duty logic.
  - MODE, PRESC and DUTY read 0 and ignore writes.
  - `out_port` is registered DATA, with latency still 1 cycle.

## Structure
- Package `pwm_led_pkg` holds:
  - the address constants `ADDR_DATA`, `ADDR_SET`, `ADDR_CLR`, `ADDR_MODE`, `ADDR_PRESC`, `ADDR_DUTY_BASE`;
  - the mode encoding constants.
- Sub-module `pwm_led_timebase` contains the prescaler and phase counter.
  - Inputs: `presc`, `presc_wr`.
  - Outputs: `phase`, `wrap` (phase going to 0).
- The top level holds the register file, the duty shadows and the output compare.

## Test plan
- Reset, then read all addresses → all 0, `out_port`=0. Write DATA=0xF → `out_port`=0xF exactly 1 cycle after the write edge.
- DATA=0x5, then SET 0x2 → DATA=0x7. Then CLR 0x4 → DATA=0x3. SET and CLR read back 0.
- PWM_BITS=8, PRESC=0, MODE=0x1, DATA=0x1, DUTY0=64 → ch0 high for 64 of every 256 clocks. With DUTY0=0 → constantly low.
- PRESC=3, DUTY0=128 → 512 high clocks per 1024-clock period, measured over 3 periods.
- Change DUTY0 from 64 to 200 mid-period → current period keeps 64 high; the next period starts with 200 high, with no glitch.
- Built without `LED_PWM_EN`: MODE=1 and DUTY0=10 written → reads 0 and `out_port` follows DATA only.
